// File: rtl/event_gen_multi.sv
// Multi-channel periodic event source, round-robin merged onto one valid/ready stream.
// Optional pseudo-random gating per channel when EVGEN_LFSR_EN is defined.
module event_gen_multi #(
  parameter int DATA_W   = 32,
  parameter int N_CH     = 4,
  parameter int PERIOD_W = 32,
  parameter int DROP_W   = 16,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [N_CH*PERIOD_W-1:0]   period,
  input  logic                       rand_mode,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [CH_W-1:0]            out_ch,
  output logic [DROP_W-1:0]          drop_cnt
);

  logic [DATA_W-1:0]   r_ts;
  logic [PERIOD_W-1:0] r_cnt  [N_CH];
  logic [DATA_W-1:0]   r_slot [N_CH];
  logic [N_CH-1:0]     r_pend;
  logic [CH_W-1:0]     r_rr;

  logic [PERIOD_W-1:0] w_p [N_CH];
  logic [N_CH-1:0]     w_hit;
  logic [N_CH-1:0]     w_gate;
  logic [N_CH-1:0]     w_fire;
  logic [N_CH-1:0]     w_drop;
  logic [N_CH-1:0]     w_gvec;
  logic                w_load;
  logic                w_gnt;
  logic [CH_W-1:0]     w_gidx;
  logic [CH_W-1:0]     w_j;
  logic [CH_W-1:0]     w_rr_nxt;
  logic [5:0]          w_ndrop;
  logic [DROP_W+6:0]   w_dsum;

`ifdef EVGEN_LFSR_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (enable) begin
      r_lfsr <= {r_lfsr[14:0],
                 r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  always_comb begin
    w_gate = '1;
    for (int c = 0; c < N_CH; c++) begin
      if (rand_mode) w_gate[c] = r_lfsr[c];
    end
  end
`else
  logic w_unused_rand;
  assign w_unused_rand = rand_mode;
  assign w_gate = '1;
`endif

  // Counter wrap (hit) is independent of gating; only the event is gated.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      w_p[c]   = period[c*PERIOD_W +: PERIOD_W];
      w_hit[c] = enable && (w_p[c] != '0) &&
                 (r_cnt[c] >= w_p[c] - PERIOD_W'(1));
    end
  end

  assign w_fire = w_hit & w_gate;
  assign w_load = !out_valid || out_ready;

  always_comb begin
    w_gnt  = 1'b0;
    w_gidx = '0;
    w_gvec = '0;
    w_j    = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_j = CH_W'((int'(r_rr) + i) % N_CH);
      if (!w_gnt && r_pend[w_j]) begin
        w_gnt  = 1'b1;
        w_gidx = w_j;
      end
    end
    if (w_gnt && w_load) w_gvec[w_gidx] = 1'b1;
  end

  assign w_rr_nxt = (w_gidx == CH_W'(N_CH - 1)) ? '0 : w_gidx + CH_W'(1);
  assign w_drop   = w_fire & r_pend & ~w_gvec;

  always_comb begin
    w_ndrop = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_ndrop = w_ndrop + 6'(w_drop[c]);
    end
    w_dsum = (DROP_W+7)'(drop_cnt) + (DROP_W+7)'(w_ndrop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts <= '0;
      for (int c = 0; c < N_CH; c++) begin
        r_cnt[c]  <= '0;
        r_slot[c] <= '0;
      end
    end else begin
      if (enable) r_ts <= r_ts + DATA_W'(1);
      for (int c = 0; c < N_CH; c++) begin
        if (w_p[c] == '0) begin
          r_cnt[c] <= '0;
        end else if (enable) begin
          r_cnt[c] <= w_hit[c] ? '0 : r_cnt[c] + PERIOD_W'(1);
        end
        if (w_fire[c] && (!r_pend[c] || w_gvec[c])) r_slot[c] <= r_ts;
      end
    end
  end

  // A fire on a channel being granted refills the slot without a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_fire[c])      r_pend[c] <= 1'b1;
        else if (w_gvec[c]) r_pend[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (w_ndrop != '0) begin
      if (w_dsum > (DROP_W+7)'({DROP_W{1'b1}})) drop_cnt <= '1;
      else drop_cnt <= w_dsum[DROP_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      r_rr      <= '0;
    end else if (w_load) begin
      out_valid <= w_gnt;
      if (w_gnt) begin
        out_data <= r_slot[w_gidx];
        out_ch   <= w_gidx;
        r_rr     <= w_rr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_event_gen_multi.sv
// Directed self-checking bench for event_gen_multi (N_CH=4).
// LFSR gating case runs only when EVGEN_LFSR_EN is defined.
module tb_event_gen_multi;

  localparam int N  = 4;
  localparam int PW = 32;
  localparam int DW = 32;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [N*PW-1:0] period;
  logic          rand_mode;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic [RW-1:0] drop_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int       ch;
    logic [63:0] data;
    int       cy;
  } ev_t;

  ev_t q[$];

  event_gen_multi #(
    .DATA_W(DW), .N_CH(N), .PERIOD_W(PW), .DROP_W(RW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period),
    .rand_mode(rand_mode), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      q.push_back('{int'(out_ch), 64'(out_data), cyc});
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic set_p(input int a, input int b, input int c, input int d);
    period[0*PW +: PW] = PW'(a);
    period[1*PW +: PW] = PW'(b);
    period[2*PW +: PW] = PW'(c);
    period[3*PW +: PW] = PW'(d);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b0;
    rand_mode = 1'b0;
    period    = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    q.delete();
  endtask

  task automatic wait_ev(input int n, input int lim);
    for (int i = 0; i < lim && q.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #2;
  endtask

`ifdef EVGEN_LFSR_EN
  logic [15:0] m_lfsr;
  int          m_exp[$];
`endif

  initial begin
    do_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_ch", 64'(out_ch), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);

    // single channel, period 10
    set_p(10, 0, 0, 0);
    out_ready = 1'b1;
    enable    = 1'b1;
    wait_ev(3, 60);
    check("p10_n", 64'(q.size()), 64'd3);
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      check("p10_data", q[i].data, 64'(9 + 10 * i));
      check("p10_ch", 64'(q[i].ch), 64'd0);
    end
    if (q.size() >= 2) check("p10_gap", 64'(q[1].cy - q[0].cy), 64'd10);
    check("p10_drop", 64'(drop_cnt), 64'd0);

    // four channels in lockstep
    do_reset();
    set_p(4, 4, 4, 4);
    out_ready = 1'b1;
    enable    = 1'b1;
    wait_ev(8, 60);
    check("p4_n", 64'(q.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      check("p4_ch", 64'(q[i].ch), 64'(i % 4));
      check("p4_data", q[i].data, 64'(3 + 4 * (i / 4)));
    end
    if (q.size() >= 4) check("p4_b2b", 64'(q[3].cy - q[0].cy), 64'd3);
    check("p4_drop", 64'(drop_cnt), 64'd0);

    // backpressure, overflow, then drain
    do_reset();
    set_p(2, 0, 0, 0);
    enable = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("bp_hold10", 64'(out_data), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_data", 64'(out_data), 64'd1);
    check("bp_drop", 64'(drop_cnt), 64'd8);
    #1;
    out_ready = 1'b1;
    set_p(0, 0, 0, 0);
    wait_ev(2, 20);
    repeat (5) @(posedge clk);
    check("bp_n", 64'(q.size()), 64'd2);
    if (q.size() >= 2) begin
      check("bp_ev0", q[0].data, 64'd1);
      check("bp_ev1", q[1].data, 64'd3);
    end
    check("bp_after", 64'(out_valid), 64'd0);

    // enable pause mid-period
    do_reset();
    set_p(10, 0, 0, 0);
    out_ready = 1'b1;
    enable    = 1'b1;
    repeat (14) @(posedge clk);
    #2 enable = 1'b0;
    repeat (5) @(posedge clk);
    #2 enable = 1'b1;
    wait_ev(2, 80);
    check("en_n", 64'(q.size()), 64'd2);
    if (q.size() >= 2) begin
      check("en_ev0", q[0].data, 64'd9);
      check("en_ev1", q[1].data, 64'd19);
      check("en_gap", 64'(q[1].cy - q[0].cy), 64'd15);
    end

    // async reset while holding an event
    do_reset();
    set_p(5, 0, 0, 0);
    enable = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("ar_valid", 64'(out_valid), 64'd1);
    check("ar_data", 64'(out_data), 64'd4);
    check("ar_drop", 64'(drop_cnt), 64'd4);
    #1 rst = 1'b1;
    #1;
    check("ar_valid0", 64'(out_valid), 64'd0);
    check("ar_drop0", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    wait_ev(1, 30);
    check("ar_n", 64'(q.size() >= 1), 64'd1);
    if (q.size() >= 1) check("ar_ev0", q[0].data, 64'd4);

    // two channels at period 1: contention drops
    do_reset();
    set_p(1, 1, 0, 0);
    out_ready = 1'b1;
    enable    = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("c1_drop", 64'(drop_cnt), 64'd9);
    #1;
    check("c1_n", 64'(q.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      check("c1_ch", 64'(q[i].ch), 64'(i % 2));
      check("c1_data", q[i].data, 64'((i == 0) ? 0 : i - 1));
    end

`ifdef EVGEN_LFSR_EN
    do_reset();
    set_p(1, 0, 0, 0);
    rand_mode = 1'b1;
    out_ready = 1'b1;
    enable    = 1'b1;
    m_lfsr    = 16'hACE1;
    m_exp.delete();
    for (int k = 0; k < 1000; k++) begin
      if (m_lfsr[0]) m_exp.push_back(k);
      m_lfsr = {m_lfsr[14:0],
                m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    repeat (1000) @(posedge clk);
    #2 set_p(0, 0, 0, 0);
    repeat (6) @(posedge clk);
    check("lf_n", 64'(q.size()), 64'(m_exp.size()));
    for (int i = 0; i < m_exp.size() && i < q.size(); i++)
      check("lf_data", q[i].data, 64'(m_exp[i]));
    check("lf_drop", 64'(drop_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
